// File: rtl/bus_controller_n.sv
`default_nettype none
// ============================================================================
// bus_controller_n : round-robin shared-bus controller with grant hold and
//                    transfer-timeout watchdog.          Revision: 1.0
// ============================================================================
module bus_controller_n #(
    parameter int MASTER_COUNT       = 4,
    parameter int SLAVE_COUNT        = 8,
    parameter int ADDRESS_WIDTH      = 30,
    parameter int DATA_WIDTH         = 32,
    parameter int SLAVE_SELECT_WIDTH = 3,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [MASTER_COUNT-1:0]             master_request_,
    input  logic [MASTER_COUNT*ADDRESS_WIDTH-1:0] master_address,
    input  logic [MASTER_COUNT-1:0]             master_address_strobe_,
    input  logic [MASTER_COUNT-1:0]             master_read_write,
    input  logic [MASTER_COUNT*DATA_WIDTH-1:0]  master_write_data,
    output logic [MASTER_COUNT-1:0]             master_grant_,
    output logic [DATA_WIDTH-1:0]               master_read_data,
    output logic                                master_ready_,
    output logic                                master_error_,
    output logic [ADDRESS_WIDTH-1:0]            slave_address,
    output logic                                slave_address_strobe_,
    output logic                                slave_read_write,
    output logic [DATA_WIDTH-1:0]               slave_write_data,
    output logic [SLAVE_COUNT-1:0]              slave_chip_select_,
    input  logic [SLAVE_COUNT*DATA_WIDTH-1:0]   slave_read_data,
    input  logic [SLAVE_COUNT-1:0]              slave_ready_
);

    localparam int OWNER_WIDTH = $clog2(MASTER_COUNT);
    localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] OWNED = 1'b1;

    logic [0:0]                    state;
    logic [0:0]                    state_next;
    logic [OWNER_WIDTH-1:0]        owner;
    logic [OWNER_WIDTH-1:0]        owner_next;
    logic [OWNER_WIDTH-1:0]        scan_owner;
    logic [OWNER_WIDTH-1:0]        candidate;
    logic                          scan_found;
    logic [MASTER_COUNT-1:0]       grant_next;
    logic                          pending;
    logic [COUNT_WIDTH-1:0]        count;
    logic [SLAVE_SELECT_WIDTH-1:0] select_index;
    logic                          selected_ready_;
    logic [DATA_WIDTH-1:0]         selected_data;
    logic                          timeout_fire;

    // Circular search starting just after the current owner; the owner itself is last.
    always_comb begin
        scan_found = 1'b0;
        scan_owner = owner;
        candidate  = owner;
        for (int k = 1; k <= MASTER_COUNT; k++) begin
            candidate = OWNER_WIDTH'((int'(owner) + k) % MASTER_COUNT);
            if (!scan_found && !master_request_[candidate]) begin
                scan_found = 1'b1;
                scan_owner = candidate;
            end
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        if (state == IDLE) begin
            if (scan_found) begin
                state_next = OWNED;
                owner_next = scan_owner;
            end
        end else if (master_request_[owner] && !pending) begin
            if (scan_found) begin
                owner_next = scan_owner;
            end else begin
                state_next = IDLE;
            end
        end
        for (int i = 0; i < MASTER_COUNT; i++) begin
            grant_next[i] = !((state_next == OWNED) && (owner_next == OWNER_WIDTH'(i)));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= OWNER_WIDTH'(MASTER_COUNT - 1);
            master_grant_ <= '1;
            pending       <= 1'b0;
            count         <= '0;
        end else begin
            state         <= state_next;
            owner         <= owner_next;
            master_grant_ <= grant_next;
            // A completing transfer always wins over a new strobe in the same cycle.
            if (!master_ready_) begin
                pending <= 1'b0;
            end else if ((state == OWNED) && !slave_address_strobe_) begin
                pending <= 1'b1;
            end
            if (!master_ready_) begin
                count <= '0;
            end else if ((TIMEOUT_CYCLES > 0) && pending && selected_ready_) begin
                count <= count + COUNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        slave_address          = '0;
        slave_address_strobe_  = 1'b1;
        slave_read_write       = 1'b1;
        slave_write_data       = '0;
        if (state == OWNED) begin
            for (int i = 0; i < MASTER_COUNT; i++) begin
                if (owner == OWNER_WIDTH'(i)) begin
                    slave_address         = master_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    slave_address_strobe_ = master_address_strobe_[i];
                    slave_read_write      = master_read_write[i];
                    slave_write_data      = master_write_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign select_index = slave_address[ADDRESS_WIDTH-1 -: SLAVE_SELECT_WIDTH];

    // Indices beyond SLAVE_COUNT match no slave and leave the bus unanswered.
    always_comb begin
        slave_chip_select_ = '1;
        selected_ready_    = 1'b1;
        selected_data      = '0;
        if (state == OWNED) begin
            for (int s = 0; s < SLAVE_COUNT; s++) begin
                if (select_index == SLAVE_SELECT_WIDTH'(s)) begin
                    slave_chip_select_[s] = 1'b0;
                    selected_ready_       = slave_ready_[s];
                    selected_data         = slave_read_data[s*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign timeout_fire     = (TIMEOUT_CYCLES > 0) && pending &&
                              (count == COUNT_WIDTH'(TIMEOUT_CYCLES));
    assign master_ready_    = selected_ready_ & ~timeout_fire;
    assign master_error_    = ~(timeout_fire & selected_ready_);
    assign master_read_data = (timeout_fire && selected_ready_) ? '0 : selected_data;

endmodule
`default_nettype wire

// File: tb/tb_bus_controller_n.sv
`default_nettype none
// ============================================================================
// tb_bus_controller_n : directed scenarios plus randomized traffic against a
//                       cycle-level reference model.     Revision: 1.0
// ============================================================================
module tb_bus_controller_n;

    localparam int MC  = 4;
    localparam int SC  = 6;
    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int SSW = 3;
    localparam int TO  = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [MC-1:0]     master_request_;
    logic [MC*AW-1:0]  master_address;
    logic [MC-1:0]     master_address_strobe_;
    logic [MC-1:0]     master_read_write;
    logic [MC*DW-1:0]  master_write_data;
    logic [MC-1:0]     master_grant_;
    logic [DW-1:0]     master_read_data;
    logic              master_ready_;
    logic              master_error_;
    logic [AW-1:0]     slave_address;
    logic              slave_address_strobe_;
    logic              slave_read_write;
    logic [DW-1:0]     slave_write_data;
    logic [SC-1:0]     slave_chip_select_;
    logic [SC*DW-1:0]  slave_read_data;
    logic [SC-1:0]     slave_ready_;

    bus_controller_n #(
        .MASTER_COUNT(MC), .SLAVE_COUNT(SC), .ADDRESS_WIDTH(AW),
        .DATA_WIDTH(DW), .SLAVE_SELECT_WIDTH(SSW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .master_request_(master_request_), .master_address(master_address),
        .master_address_strobe_(master_address_strobe_),
        .master_read_write(master_read_write), .master_write_data(master_write_data),
        .master_grant_(master_grant_), .master_read_data(master_read_data),
        .master_ready_(master_ready_), .master_error_(master_error_),
        .slave_address(slave_address), .slave_address_strobe_(slave_address_strobe_),
        .slave_read_write(slave_read_write), .slave_write_data(slave_write_data),
        .slave_chip_select_(slave_chip_select_), .slave_read_data(slave_read_data),
        .slave_ready_(slave_ready_)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: who holds the bus, whether a transfer is outstanding, how long it has waited.
    bit m_busy;
    int m_owner;
    bit m_pend;
    int m_wait;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = MC - 1;
        m_pend  = 1'b0;
        m_wait  = 0;
    endtask

    // Checks the current cycle against the model, advances the model, then moves to the next negedge.
    task automatic step();
        logic [MC-1:0] g_exp;
        logic [AW-1:0] a_exp;
        logic [DW-1:0] wd_exp;
        logic [DW-1:0] d_exp;
        logic [SC-1:0] cs_exp;
        logic          stb_exp;
        logic          rw_exp;
        bit            mapped, srdy, tmo, r_exp, e_exp, found, old_pend;
        int            slv, nxt;
        #1;
        g_exp   = '1;
        a_exp   = '0;
        stb_exp = 1'b1;
        rw_exp  = 1'b1;
        wd_exp  = '0;
        if (m_busy) begin
            g_exp[m_owner] = 1'b0;
            a_exp   = master_address[m_owner*AW +: AW];
            stb_exp = master_address_strobe_[m_owner];
            rw_exp  = master_read_write[m_owner];
            wd_exp  = master_write_data[m_owner*DW +: DW];
        end
        slv    = int'(a_exp >> (AW - SSW));
        mapped = m_busy && (slv < SC);
        cs_exp = '1;
        d_exp  = '0;
        srdy   = 1'b1;
        if (mapped) begin
            cs_exp[slv] = 1'b0;
            d_exp       = slave_read_data[slv*DW +: DW];
            srdy        = slave_ready_[slv];
        end
        tmo = (TO > 0) && m_pend && (m_wait == TO);
        if (!srdy) begin
            r_exp = 1'b0; e_exp = 1'b1;
        end else if (tmo) begin
            r_exp = 1'b0; e_exp = 1'b0; d_exp = '0;
        end else begin
            r_exp = 1'b1; e_exp = 1'b1;
        end
        check_value("grant", master_grant_, g_exp);
        check_value("s_addr", slave_address, a_exp);
        check_value("s_strobe", slave_address_strobe_, stb_exp);
        check_value("s_rw", slave_read_write, rw_exp);
        check_value("s_wdata", slave_write_data, wd_exp);
        check_value("chip_sel", slave_chip_select_, cs_exp);
        check_value("rdata", master_read_data, d_exp);
        check_value("ready", master_ready_, r_exp);
        check_value("error", master_error_, e_exp);

        old_pend = m_pend;
        if (!r_exp) begin
            m_pend = 1'b0;
            m_wait = 0;
        end else begin
            if (m_pend && srdy) m_wait++;
            if (m_busy && !stb_exp) m_pend = 1'b1;
        end
        if (!(m_busy && (!master_request_[m_owner] || old_pend))) begin
            found = 1'b0;
            for (int k = 1; k <= MC; k++) begin
                nxt = (m_owner + k) % MC;
                if (!found && !master_request_[nxt]) begin
                    found   = 1'b1;
                    m_owner = nxt;
                end
            end
            m_busy = found;
        end
        @(negedge clock);
    endtask

    task automatic randomize_inputs();
        logic [AW-1:0] a;
        for (int i = 0; i < MC; i++) begin
            if ($urandom_range(7) == 0) master_request_[i] = ~master_request_[i];
            master_address_strobe_[i] = ($urandom_range(2) != 0);
            master_read_write[i]      = 1'($urandom);
            a                         = AW'($urandom);
            a[AW-1 -: SSW]            = SSW'($urandom_range(7));
            master_address[i*AW +: AW]    = a;
            master_write_data[i*DW +: DW] = $urandom;
        end
        for (int s = 0; s < SC; s++) begin
            slave_ready_[s]              = ($urandom_range(3) != 0);
            slave_read_data[s*DW +: DW]  = $urandom;
        end
    endtask

    initial begin
        master_request_        = '1;
        master_address         = '0;
        master_address_strobe_ = '1;
        master_read_write      = '1;
        master_write_data      = '0;
        slave_ready_           = '1;
        slave_read_data        = '0;
        model_reset();

        repeat (2) @(negedge clock);
        #1;
        check_value("rst_grant", master_grant_, 4'hF);
        check_value("rst_ready", master_ready_, 1'b1);
        check_value("rst_error", master_error_, 1'b1);
        check_value("rst_cs", slave_chip_select_, 6'h3F);
        @(negedge clock);
        reset = 1'b0;

        // Masters 0 and 2 together, then 0 releases.
        master_request_ = 4'b1010; step();
        check_value("tp1_first", master_grant_, 4'b1110);
        master_request_ = 4'b1011; step();
        check_value("tp1_second", master_grant_, 4'b1011);

        // Wrap from master 3 back to master 0, then on to 1.
        master_request_ = 4'b0111; step();
        check_value("tp2_own3", master_grant_, 4'b0111);
        master_request_ = 4'b1100; step();
        check_value("tp2_wrap", master_grant_, 4'b1110);
        master_request_ = 4'b1101; step();
        check_value("tp2_next", master_grant_, 4'b1101);

        // Decode to slave 2 and return its data.
        master_address[1*AW +: AW]  = 30'h1000_0000;
        slave_read_data[2*DW +: DW] = 32'hDEAD_BEEF;
        slave_ready_                = 6'b111011;
        #1;
        check_value("tp3_cs", slave_chip_select_, 6'b111011);
        check_value("tp3_rdata", master_read_data, 32'hDEAD_BEEF);
        check_value("tp3_ready", master_ready_, 1'b0);
        step();

        // Grant held through a stalled transfer after the owner drops its request.
        slave_ready_ = '1;
        master_address_strobe_[1] = 1'b0; step();
        master_address_strobe_[1] = 1'b1;
        master_request_ = 4'b1110;
        for (int c = 0; c < 3; c++) begin
            step();
            check_value("tp4_hold", master_grant_, 4'b1101);
        end
        slave_ready_ = 6'b111011;
        #1;
        check_value("tp4_ready", master_ready_, 1'b0);
        check_value("tp4_noerr", master_error_, 1'b1);
        step();
        check_value("tp4_held_on_ready", master_grant_, 4'b1101);
        slave_ready_ = '1; step();
        check_value("tp4_handover", master_grant_, 4'b1110);

        // Unmapped slave index 7: watchdog completes on the fifth pending cycle.
        master_address[0 +: AW] = 30'h3800_0000;
        master_address_strobe_[0] = 1'b0; step();
        master_address_strobe_[0] = 1'b1;
        for (int p = 1; p <= 5; p++) begin
            #1;
            if (p == 5) begin
                check_value("tp5_ready", master_ready_, 1'b0);
                check_value("tp5_error", master_error_, 1'b0);
                check_value("tp5_rdata", master_read_data, 32'h0);
            end else begin
                check_value("tp5_wait", master_ready_, 1'b1);
            end
            step();
        end
        #1;
        check_value("tp5_after_ready", master_ready_, 1'b1);
        check_value("tp5_after_error", master_error_, 1'b1);
        step();

        // Asynchronous reset while a transfer is outstanding.
        master_address[0 +: AW] = 30'h1000_0000;
        master_address_strobe_[0] = 1'b0; step();
        master_address_strobe_[0] = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_value("tp6_grant", master_grant_, 4'hF);
        check_value("tp6_cs", slave_chip_select_, 6'h3F);
        check_value("tp6_ready", master_ready_, 1'b1);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        master_request_ = 4'b0110; step();
        check_value("tp6_first", master_grant_, 4'b1110);

        repeat (3000) begin
            randomize_inputs();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
